// File: rtl/exe_stage.sv
// ============================================================================
// Module   : exe_stage
// Purpose  : Pipeline execute stage. Single-cycle ALU plus an optional
//            32-step shift-add multiplier (enabled by macro EXE_MUL_EN),
//            with stall request and EXE/MEM output register.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module exe_stage #(
    parameter int DATA_W    = 32,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    exe_reg1_o,
    input  logic [DATA_W-1:0]    exe_reg2_o,
    input  logic [DATA_W-1:0]    exe_sw_o,
    input  logic [DATA_W-1:0]    exe_write_o,
    input  logic [ALUCTRL_W-1:0] exe_aluctrl,
    input  logic                 exe_movsrc,
    input  logic                 exe_lwsrc,
    input  logic                 exe_DM_read,
    input  logic                 exe_DM_write,
    input  logic                 exe_flush,
    output logic                 stall_req,
    output logic [DATA_W-1:0]    mem_alu_result,
    output logic [DATA_W-1:0]    mem_sw_o,
    output logic [DATA_W-1:0]    mem_write_o,
    output logic                 mem_lwsrc,
    output logic                 mem_DM_read,
    output logic                 mem_DM_write
);

    localparam int c_SH_W = $clog2(DATA_W);

    localparam logic [ALUCTRL_W-1:0] c_op_add = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] c_op_sub = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] c_op_and = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] c_op_or  = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] c_op_xor = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] c_op_sll = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] c_op_srl = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] c_op_sra = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] c_op_slt = ALUCTRL_W'(9);

    logic [c_SH_W-1:0]  w_shamt;
    logic               w_slt;
    logic [DATA_W-1:0]  w_alu;
    logic [DATA_W-1:0]  w_single;
    logic               w_bubble;
    logic               w_use_prod;
    logic [DATA_W-1:0]  w_prod;

    logic [DATA_W-1:0]  result_q, result_d;
    logic [DATA_W-1:0]  sw_q, sw_d;
    logic [DATA_W-1:0]  write_q, write_d;
    logic               lwsrc_q, lwsrc_d;
    logic               dmrd_q, dmrd_d;
    logic               dmwr_q, dmwr_d;

    assign w_shamt = exe_reg2_o[c_SH_W-1:0];
    assign w_slt   = $signed(exe_reg1_o) < $signed(exe_reg2_o);

    // MUL and undefined codes fall to the default: the product path is separate.
    always_comb begin
        w_alu = '0;
        case (exe_aluctrl)
            c_op_add: w_alu = exe_reg1_o + exe_reg2_o;
            c_op_sub: w_alu = exe_reg1_o - exe_reg2_o;
            c_op_and: w_alu = exe_reg1_o & exe_reg2_o;
            c_op_or:  w_alu = exe_reg1_o | exe_reg2_o;
            c_op_xor: w_alu = exe_reg1_o ^ exe_reg2_o;
            c_op_sll: w_alu = exe_reg1_o << w_shamt;
            c_op_srl: w_alu = exe_reg1_o >> w_shamt;
            c_op_sra: w_alu = DATA_W'($signed(exe_reg1_o) >>> w_shamt);
            c_op_slt: w_alu = {{(DATA_W-1){1'b0}}, w_slt};
            default:  w_alu = '0;
        endcase
    end

    assign w_single = exe_movsrc ? exe_reg2_o : w_alu;

`ifdef EXE_MUL_EN
    localparam logic [ALUCTRL_W-1:0] c_op_mul = ALUCTRL_W'(10);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_SH_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]  mcand_q, mcand_d;
    logic [DATA_W-1:0]  mplier_q, mplier_d;
    logic [DATA_W-1:0]  prod_q, prod_d;
    logic               w_mul_req;

    // A move overrides MUL, so it never starts the multiplier.
    assign w_mul_req = (exe_aluctrl == c_op_mul) && !exe_movsrc;
    assign w_prod    = prod_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        stall_req  = 1'b0;
        w_bubble   = 1'b0;
        w_use_prod = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_mul_req && !exe_flush) begin
                    stall_req = 1'b1;
                    w_bubble  = 1'b1;
                    state_d   = ST_BUSY;
                    mcand_d   = exe_reg1_o;
                    mplier_d  = exe_reg2_o;
                    prod_d    = '0;
                    cnt_d     = '0;
                end
            end
            ST_BUSY: begin
                stall_req = 1'b1;
                w_bubble  = 1'b1;
                if (mplier_q[0]) begin
                    prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '1) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                w_use_prod = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (exe_flush) begin
            state_d = ST_IDLE;
        end
        if (rst) begin
            stall_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end
`else
    assign stall_req  = 1'b0;
    assign w_bubble   = 1'b0;
    assign w_use_prod = 1'b0;
    assign w_prod     = '0;
`endif

    always_comb begin
        result_d = '0;
        sw_d     = '0;
        write_d  = '0;
        lwsrc_d  = 1'b0;
        dmrd_d   = 1'b0;
        dmwr_d   = 1'b0;
        if (!exe_flush && !w_bubble) begin
            result_d = w_use_prod ? w_prod : w_single;
            sw_d     = exe_sw_o;
            write_d  = exe_write_o;
            lwsrc_d  = exe_lwsrc;
            dmrd_d   = exe_DM_read;
            dmwr_d   = exe_DM_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            sw_q     <= '0;
            write_q  <= '0;
            lwsrc_q  <= 1'b0;
            dmrd_q   <= 1'b0;
            dmwr_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            sw_q     <= sw_d;
            write_q  <= write_d;
            lwsrc_q  <= lwsrc_d;
            dmrd_q   <= dmrd_d;
            dmwr_q   <= dmwr_d;
        end
    end

    assign mem_alu_result = result_q;
    assign mem_sw_o       = sw_q;
    assign mem_write_o    = write_q;
    assign mem_lwsrc      = lwsrc_q;
    assign mem_DM_read    = dmrd_q;
    assign mem_DM_write   = dmwr_q;

endmodule

`default_nettype wire

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: cycle model of the stage plus directed vectors
// with literal expectations. Honours EXE_MUL_EN like the design.
`default_nettype none

module tb_exe_stage;

`ifdef EXE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] reg1 = '0, reg2 = '0, sw = '0, wr = '0;
    logic [3:0]  ctrl = '0;
    logic        movsrc = 1'b0, lwsrc = 1'b0, dmrd = 1'b0, dmwr = 1'b0, flush = 1'b0;

    logic        stall;
    logic [31:0] m_res, m_sw, m_wr;
    logic        m_lw, m_rd, m_wrm;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    exe_stage #(.DATA_W(32), .ALUCTRL_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .exe_reg1_o     (reg1),
        .exe_reg2_o     (reg2),
        .exe_sw_o       (sw),
        .exe_write_o    (wr),
        .exe_aluctrl    (ctrl),
        .exe_movsrc     (movsrc),
        .exe_lwsrc      (lwsrc),
        .exe_DM_read    (dmrd),
        .exe_DM_write   (dmwr),
        .exe_flush      (flush),
        .stall_req      (stall),
        .mem_alu_result (m_res),
        .mem_sw_o       (m_sw),
        .mem_write_o    (m_wr),
        .mem_lwsrc      (m_lw),
        .mem_DM_read    (m_rd),
        .mem_DM_write   (m_wrm)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase 0: no multiply; 1..32: cycles spent iterating; 33: result cycle.
    int          phase = 0;
    logic [31:0] ma = '0, mb = '0;
    logic [31:0] e_res = '0, e_sw = '0, e_wr = '0;
    logic        e_lw = 1'b0, e_rd = 1'b0, e_wrm = 1'b0;

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int          sh;
        sh  = int'(b[4:0]);
        ext = {{32{a[31]}}, a};
        case (op)
            4'd1:    return a + b;
            4'd2:    return a + ~b + 32'd1;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << sh;
            4'd7:    return a >> sh;
            4'd8:    return ext[sh +: 32];
            4'd9:    return ((a[31] && !b[31]) || ((a[31] == b[31]) && (a < b))) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit mul_issue();
        return MUL_EN && (ctrl == 4'd10) && !movsrc;
    endfunction

    function automatic logic exp_stall();
        if (rst) return 1'b0;
        if (phase >= 1 && phase <= 32) return 1'b1;
        if (phase == 0 && mul_issue() && !flush) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (rst || flush || (phase == 0 && mul_issue()) || (phase >= 1 && phase <= 32)) begin
            e_res <= '0; e_sw <= '0; e_wr <= '0;
            e_lw  <= 1'b0; e_rd <= 1'b0; e_wrm <= 1'b0;
            if (rst || flush) begin
                phase <= 0;
            end else if (phase == 0) begin
                phase <= 1; ma <= reg1; mb <= reg2;
            end else begin
                phase <= phase + 1;
            end
        end else begin
            e_res <= (phase == 33) ? ma * mb : (movsrc ? reg2 : alu(ctrl, reg1, reg2));
            e_sw  <= sw; e_wr <= wr;
            e_lw  <= lwsrc; e_rd <= dmrd; e_wrm <= dmwr;
            phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall_req", {31'd0, stall}, {31'd0, exp_stall()});
            check("mem_alu_result", m_res, e_res);
            check("mem_sw_o", m_sw, e_sw);
            check("mem_write_o", m_wr, e_wr);
            check("mem_ctrl", {29'd0, m_lw, m_rd, m_wrm}, {29'd0, e_lw, e_rd, e_wrm});
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mv, input logic fl);
        ctrl = op; reg1 = a; reg2 = b; movsrc = mv; flush = fl;
        sw = a ^ 32'h5A5A_0000; wr = b + 32'd1;
        lwsrc = a[0]; dmrd = b[0]; dmwr = a[1];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
        set_in(op, a, b, 1'b0, 1'b0);
        tick();
        check(name, m_res, exp);
    endtask

    // Holds a MUL until the stall drops, then lets the result edge pass.
    task automatic mul_op(input logic [31:0] a, input logic [31:0] b, output int n_stall);
        n_stall = 0;
        set_in(4'd10, a, b, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) break;
            n_stall++;
            if (m_res !== 32'd0 || m_rd !== 1'b0) check("mul_bubble", m_res, 32'd0);
            tick();
        end
        tick();
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        set_in(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        cmp_en = 1'b1;
        check("reset_result", m_res, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;

        single(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, "add_wrap");
        single(4'd2, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap");
        single(4'd8, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra");
        single(4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, "slt_neg");
        single(4'd9, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, "slt_pos");
        single(4'd7, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, "srl31");
        single(4'd6, 32'h0000_0003, 32'h0000_0004, 32'h0000_0030, "sll");
        single(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor");
        single(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and");
        single(4'd4, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, "or");
        single(4'd13, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, "undef_op");

        // Multiply with passthroughs: lwsrc=1, DM_read=0, DM_write=0 from the operands.
        mul_op(32'h0001_2345, 32'h0000_0100, n);
        check("mul_stall_cycles", n, MUL_EN ? 32'd33 : 32'd0);
        check("mul_result", m_res, MUL_EN ? 32'h0123_4500 : 32'd0);
        check("mul_sw", m_sw, 32'h5A5B_2345);
        check("mul_lwsrc", {31'd0, m_lw}, 32'd1);

        // Flush at iteration 10 of the multiply.
        set_in(4'd10, 32'h0000_0007, 32'h0000_0009, 1'b0, 1'b0);
        repeat (11) tick();
        flush = 1'b1;
        tick();
        set_in(4'd1, 32'd5, 32'd7, 1'b0, 1'b0);
        check("flush_stall_drop", {31'd0, stall}, 32'd0);
        check("flush_bubble", m_res, 32'd0);
        tick();
        check("add_after_flush", m_res, 32'd12);

        // Reset part-way through a multiply, then a full multiply again.
        set_in(4'd10, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0);
        repeat (6) tick();
        rst = 1'b1;
        #3;
        check("stall_in_rst", {31'd0, stall}, 32'd0);
        tick();
        check("rst_mid_result", m_res, 32'd0);
        check("rst_mid_write", m_wr, 32'd0);
        rst = 1'b0;
        mul_op(32'h0000_0007, 32'h0000_0006, n);
        check("mul2_stall_cycles", n, MUL_EN ? 32'd33 : 32'd0);
        check("mul2_result", m_res, MUL_EN ? 32'd42 : 32'd0);

        // Move overrides MUL.
        set_in(4'd10, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1, 1'b0);
        #3;
        check("move_no_stall", {31'd0, stall}, 32'd0);
        tick();
        check("move_result", m_res, 32'hDEAD_BEEF);

        single(4'd1, 32'h1000_0000, 32'h0000_0001, 32'h1000_0001, "add_tail");
        set_in(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
